seg_scanner: RTL and testbench
==============================

// Module: seg_scanner
// PURPOSE
//  Multiplexed 7-segment display driver that sits directly downstream of the clock divider.
//  Samples the divider's clk_out as a DATA signal (never as a clock) and advances one digit per rising edge.
//  Shows a DIGITS-wide hex word (CPU PC/register/debug value) on common-anode displays.
//  Inserts a blanking gap between digits to suppress ghosting.
// PARAMETERS
//  DIGITS        8   number of digits; data_in is 4*DIGITS bits, digit 0 = data_in[3:0]
//  BLANK_CYCLES  16  clk cycles with all anodes off between digits (>=1)
// PORTS
//  clk         in   1          system clock, single clock domain
//  reset       in   1          asynchronous, active-low reset
//  scan_in     in   1          clk_out from clk_divider, treated as asynchronous data
//  data_in     in   4*DIGITS   hex value to display
//  data_valid  in   1          1-cycle strobe: capture data_in
//  dp_in       in   DIGITS     decimal points, 1 = lit
//  an          out  DIGITS     anode enables, active-low
//  seg         out  7          cathodes {g,f,e,d,c,b,a}, active-low
//  dp          out  1          decimal-point cathode, active-low
//  frame_done  out  1          1-cycle pulse when the last digit's dwell ends (index wraps to 0)
// BEHAVIOUR
//  Reset (async assert, sync to clk on deassert in the enclosing design):
//   - Outputs: an='1s, seg=7'h7F, dp=1, frame_done=0.
//   - Internal: state=BLANK, blank_cnt=0, idx=0, pending/shown registers=0, sync FFs=0.
//  Scan input:
//   - 2-FF synchronizer, then rising-edge detect -> scan_step.
//   - scan_step is asserted 3 clk cycles after scan_in rises.
//  data_valid:
//   - data_in/dp_in are captured into the pending registers on the same edge.
//   - A later strobe overwrites an earlier one (last wins).
//  Commit:
//   - pending -> shown only when idx wraps DIGITS-1 -> 0, so there is no tearing within a frame.
//   - A strobe in the same cycle as a wrap is committed at the NEXT wrap.
//  FSM:
//   - BLANK: an='1s; blank_cnt counts 0..BLANK_CYCLES-1, then -> SHOW (blank_cnt cleared).
//   - SHOW: an[idx]=0, seg=decode(shown[idx]), dp=~dp_shown[idx].
//     On scan_step -> BLANK, idx <= (idx==DIGITS-1) ? 0 : idx+1.
//   - scan_step while in BLANK is dropped; the divider period must exceed BLANK_CYCLES.
//  frame_done:
//   - Pulses in the cycle SHOW->BLANK with idx==DIGITS-1, coincident with the commit.
//  Timing:
//   - All outputs are registered.
//   - an changes one cycle after the FSM transition; seg/dp change in the same cycle as an.
//  Reset mid-frame:
//   - Outputs return to reset values immediately; pending data is lost.
//   - After release, scanning restarts at digit 0 showing 0.
//  idx width: $clog2(DIGITS), minimum 1.
// CONFIGURATION
//  Macro SEG_LZB_EN (leading-zero blanking).
//  Defined:
//   - Digits above the most-significant nonzero nibble of shown keep their anode off during SHOW.
//   - Digit 0 is always lit.
//   - Blanking is recomputed at each commit.
//  Undefined:
//   - Every digit is lit; leading zeros are shown as '0'.
// STRUCTURE
//  Shared include seg_defs.vh:
//   - SEG_0..SEG_F active-low segment constants.
//   - SEG_OFF=7'h7F.
//   - FSM state encodings S_BLANK/S_SHOW.
//  Sub-module hex_to_seg:
//   - Combinational 4-bit -> 7-bit active-low decoder.
//   - Instantiated once on the selected nibble.
//  Top level: synchronizer, edge detector, FSM, counters, pending/shown registers.
// TESTING (DIGITS=8, BLANK_CYCLES=16 unless noted)
//  1 Reset:
//   - Hold reset=0 mid-SHOW -> an=8'hFF, seg=7'h7F, dp=1 immediately.
//   - Release -> first lit digit is an=8'hFE, seg=SEG_0.
//  2 Scan:
//   - data_valid with 32'h1234_ABCD, then 8 scan_in pulses.
//   - Digits 0..7 show D,C,B,A,4,3,2,1 with an walking FE..7F.
//   - 16 cycles of an=FF between digits; frame_done pulses once per frame.
//  3 No tearing:
//   - Strobe 32'h0000_0055 mid-frame -> remaining digits still show the old value.
//   - New value appears from digit 0 after the wrap.
//  4 Simultaneous:
//   - Strobe in the same cycle as the wrap -> value appears one frame later.
//   - Two strobes in one frame -> only the last one is displayed.
//  5 Dropped edge:
//   - scan_in edge during BLANK -> idx unchanged, digit not skipped.
//  6 SEG_LZB_EN:
//   - data 32'h0000_00A0 -> only digits 0,1 lit (SEG_0, SEG_A).
//   - data 0 -> only digit 0 lit.
//   - Without the macro, all 8 digits are lit.

Source files
------------

// File: rtl/seg_scanner_pkg.sv
// Shared definitions for the 7-segment scanner: segment patterns and FSM states.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// No logic lives here; imported by seg_scanner and hex_to_seg.
package seg_scanner_pkg;

   // Active-low cathode patterns for hex glyphs 0..F
   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_A   = 7'h08;
   localparam logic [6:0] SEG_B   = 7'h03;
   localparam logic [6:0] SEG_C   = 7'h46;
   localparam logic [6:0] SEG_D   = 7'h21;
   localparam logic [6:0] SEG_E   = 7'h06;
   localparam logic [6:0] SEG_F   = 7'h0E;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Scanner FSM: blanking gap between digits, then dwell on one digit
   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

endpackage

// File: rtl/seg_scanner_hex_to_seg.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
module hex_to_seg
   import seg_scanner_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   // Glyph lookup for one nibble
   always_comb begin
      o_seg = SEG_OFF;
      case (i_nib)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed common-anode 7-segment driver stepped by rising edges of scan_in (sampled as data).
// Latency: scan_in rise -> FSM step 4 clk edges later; outputs registered, one cycle behind the FSM.
// Backpressure: none; scan edges arriving during the blanking gap are dropped. SEG_LZB_EN enables leading-zero blanking.
module seg_scanner
   import seg_scanner_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scan_in,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  data_valid,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLANK_CYCLES - 1);

   logic                  r_sync1, r_sync2, r_sync3, r_step;
   logic [4*DIGITS-1:0]   r_pend_dat, r_shown;
   logic [DIGITS-1:0]     r_pend_dp, r_shown_dp;
   state_t                r_state;
   logic [CNT_W-1:0]      r_blank_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_frame_done;
   logic [DIGITS-1:0]     r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [3:0]            w_nib;
   logic [6:0]            w_seg;
   logic                  w_lit;

`ifdef SEG_LZB_EN
   logic [DIGITS-1:0]     r_lit_mask;

   // A digit stays lit if it or any more-significant nibble is nonzero; digit 0 always lit
   function automatic logic [DIGITS-1:0] f_lit_mask(input logic [4*DIGITS-1:0] v);
      logic seen;
      f_lit_mask = '0;
      seen       = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen          = seen | (v[4*i +: 4] != 4'h0);
         f_lit_mask[i] = seen | (i == 0);
      end
   endfunction

   assign w_lit = r_lit_mask[r_idx];
`else
   assign w_lit = 1'b1;
`endif

   assign w_nib = r_shown[{r_idx, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   // Two-flop synchronizer on scan_in, then registered rising-edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_step  <= 1'b0;
      end else begin
         r_sync1 <= scan_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_step  <= r_sync2 & ~r_sync3;
      end
   end

   // Pending registers take every strobe; the last one before a wrap wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_dat <= '0;
         r_pend_dp  <= '0;
      end else if (data_valid) begin
         r_pend_dat <= data_in;
         r_pend_dp  <= dp_in;
      end
   end

   // Scan FSM: blanking gap, digit dwell, index advance and frame-boundary commit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_BLANK;
         r_blank_cnt  <= '0;
         r_idx        <= '0;
         r_shown      <= '0;
         r_shown_dp   <= '0;
         r_frame_done <= 1'b0;
`ifdef SEG_LZB_EN
         r_lit_mask   <= DIGITS'(1);
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_BLANK: begin
               if (r_blank_cnt == LAST_CNT) begin
                  r_state     <= S_SHOW;
                  r_blank_cnt <= '0;
               end else begin
                  r_blank_cnt <= r_blank_cnt + 1'b1;
               end
            end
            S_SHOW: begin
               if (r_step) begin
                  r_state <= S_BLANK;
                  if (r_idx == LAST_IDX) begin
                     // Commit uses the pending value as of this edge, so a coincident strobe waits a frame
                     r_idx        <= '0;
                     r_shown      <= r_pend_dat;
                     r_shown_dp   <= r_pend_dp;
                     r_frame_done <= 1'b1;
`ifdef SEG_LZB_EN
                     r_lit_mask   <= f_lit_mask(r_pend_dat);
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= S_BLANK;
               r_blank_cnt <= '0;
            end
         endcase
      end
   end

   // Registered display outputs, following the FSM state by one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
         if (r_state == S_SHOW && w_lit) begin
            r_an[r_idx] <= 1'b0;
            r_seg       <= w_seg;
            r_dp        <= ~r_shown_dp[r_idx];
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: randomized scan pulses and data strobes against a frame-level display model.
// Expected digits are queued when the model advances; a negedge monitor pops them as digits light.
// Build with or without SEG_LZB_EN; the model follows the same macro.
`timescale 1ns/1ps
module tb_seg_scanner;

   localparam int DIGITS = 8;
   localparam int BLANK  = 16;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        scan_in    = 1'b0;
   logic        data_valid = 1'b0;
   logic [31:0] data_in    = '0;
   logic [7:0]  dp_in      = '0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   always #5 clk = ~clk;

   seg_scanner #(.DIGITS(DIGITS), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_in    (scan_in),
      .data_in    (data_in),
      .data_valid (data_valid),
      .dp_in      (dp_in),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   fd_q[$];

   // Standard active-high glyphs {g,f,e,d,c,b,a}; the display is active-low
   logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Display model: which digit is up, what value is committed, what is waiting
   int          m_idx;
   logic [31:0] m_pend, m_shown;
   logic [7:0]  m_pend_dp, m_shown_dp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void push_digit();
      exp_t       e;
      logic [3:0] nib;
`ifdef SEG_LZB_EN
      if (m_idx != 0 && (m_shown >> (4 * m_idx)) == 32'd0) return;
`endif
      nib   = 4'((m_shown >> (4 * m_idx)) & 32'hF);
      e.an  = ~(8'd1 << m_idx);
      e.seg = ~seg_on[nib];
      e.dp  = ~m_shown_dp[m_idx];
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset();
      m_idx      = 0;
      m_pend     = '0;
      m_shown    = '0;
      m_pend_dp  = '0;
      m_shown_dp = '0;
      exp_q.delete();
      fd_q.delete();
      push_digit();
   endfunction

   task automatic strobe(input logic [31:0] v, input logic [7:0] d);
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = v;
      dp_in      = d;
      @(negedge clk);
      data_valid = 1'b0;
      m_pend     = v;
      m_pend_dp  = d;
   endtask

   // One scan edge; optional strobe landing on the step edge, optional ghost edge inside the gap
   task automatic pulse(input bit ghost, input bit sim, input logic [31:0] sv, input logic [7:0] sdp);
      if (m_idx == DIGITS - 1) begin
         m_shown    = m_pend;
         m_shown_dp = m_pend_dp;
         fd_q.push_back(1);
         m_idx      = 0;
      end else begin
         m_idx++;
      end
      if (sim) begin
         m_pend    = sv;
         m_pend_dp = sdp;
      end
      push_digit();
      @(negedge clk);
      scan_in = 1'b1;
      repeat (3) @(negedge clk);
      if (sim) begin
         data_valid = 1'b1;
         data_in    = sv;
         dp_in      = sdp;
      end
      @(negedge clk);
      data_valid = 1'b0;
      scan_in    = 1'b0;
      if (ghost) begin
         repeat (2) @(negedge clk);
         scan_in = 1'b1;
         repeat (3) @(negedge clk);
         scan_in = 1'b0;
      end
      repeat (22) @(negedge clk);
   endtask

   // Monitor: compare each newly lit digit, the blanking gap, and frame_done pulses
   logic [7:0] prev_an   = 8'hFF;
   int         gap       = 0;
   bit         gap_valid = 1'b0;
   logic       prev_fd   = 1'b0;
   exp_t       mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         prev_an   = 8'hFF;
         gap       = 0;
         gap_valid = 1'b0;
         prev_fd   = 1'b0;
      end else begin
         if (an == 8'hFF) begin
            gap++;
         end else if (prev_an == 8'hFF) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL digit_unexpected: an=%h seg=%h with nothing expected at %0t", an, seg, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("digit_an", 32'(an), 32'(mon_e.an));
               chk("digit_seg", 32'(seg), 32'(mon_e.seg));
               chk("digit_dp", 32'(dp), 32'(mon_e.dp));
            end
`ifndef SEG_LZB_EN
            if (gap_valid) chk("blank_gap", gap, BLANK);
`endif
            gap_valid = 1'b1;
            gap       = 0;
         end
         if (frame_done) begin
            checks++;
            if (prev_fd) begin
               errors++;
               $display("FAIL frame_done_width: high %0d cycles, required 1", 2);
            end else if (fd_q.size() == 0) begin
               errors++;
               $display("FAIL frame_done_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
               void'(fd_q.pop_front());
            end
         end
         prev_fd = frame_done;
         prev_an = an;
      end
   end

   initial begin
      logic [31:0] rv;
      bit          wrap, sim, ghost;
      int          ns;

      // Reset state
      #1 reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_an", 32'(an), 32'hFF);
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_dp", 32'(dp), 32'h1);
      chk("reset_frame_done", 32'(frame_done), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);

      // Frame of zeros with 1234_ABCD pending, then a frame showing it
      strobe(32'h1234_ABCD, 8'h81);
      for (int i = 0; i < 8; i++) pulse(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++) begin
         pulse(i == 2, 1'b0, '0, '0);
         if (i == 3) strobe(32'h0000_0055, 8'h00);
      end
      for (int i = 0; i < 8; i++) pulse(1'b0, 1'b0, '0, '0);

      // Strobe coincident with wrap, then two strobes in one frame
      for (int i = 0; i < 7; i++) pulse(1'b0, 1'b0, '0, '0);
      pulse(1'b0, 1'b1, 32'h9876_5432, 8'h10);
      strobe(32'h0000_00A0, 8'h02);
      strobe(32'hFEDC_0000, 8'h00);
      for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, '0, '0);
      strobe(32'h0000_00A0, 8'h00);
      for (int i = 0; i < 8; i++) pulse(1'b0, 1'b0, '0, '0);
      strobe(32'h0000_0000, 8'h00);
      for (int i = 0; i < 16; i++) pulse(1'b0, 1'b0, '0, '0);

      // Reset while a digit is lit; pending strobe must be lost
      for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, '0, '0);
      strobe(32'h7777_7777, 8'hFF);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_an", 32'(an), 32'hFF);
      chk("midreset_seg", 32'(seg), 32'h7F);
      chk("midreset_dp", 32'(dp), 32'h1);
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      for (int i = 0; i < 16; i++) pulse(1'b0, 1'b0, '0, '0);

      // Randomized scanning with random strobes, coincident strobes and ghost edges
      for (int i = 0; i < 64; i++) begin
         wrap  = (m_idx == DIGITS - 1);
         sim   = wrap && ($urandom_range(0, 2) == 0);
         ghost = ($urandom_range(0, 3) == 0);
         rv    = $urandom >> $urandom_range(0, 31);
         pulse(ghost, sim, rv, 8'($urandom));
         ns = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
         for (int k = 0; k < ns; k++) strobe($urandom >> $urandom_range(0, 31), 8'($urandom));
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("digits_outstanding", exp_q.size(), 0);
      chk("frame_done_outstanding", fd_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
